move_request_gen: RTL and testbench

//  Conditions the four raw direction push-buttons into clean player-move requests.
//  - Synchronises and debounces each button.
//  - Picks one direction by priority.
//  - Emits single-cycle move strobes with typematic auto-repeat.

---
 rtl/move_request_gen.sv | 141 ++++++++++++++
 tb/tb_move_request_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/move_request_gen.sv
// Push-button conditioner: sync + debounce per button, U>D>R>L priority select,
// and a move-strobe generator with typematic auto-repeat.

module move_request_gen_deb #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);
  logic             s1_q, s2_q, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_d = s2_q;
      else                                      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;
endmodule

module move_request_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 40000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnR,
  input  logic       btnL,
  input  logic       holdOff,
  output logic [3:0] btns,
  output logic       moveStb,
  output logic       held
);
  typedef enum logic [1:0] {IDLE, FIRST, DELAY, RPT} state_e;

  logic [3:0]       deb, dir;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       last_q, last_d, btns_q, btns_d;
  logic             stb_q, stb_d;

  move_request_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb [3:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  ({btnU, btnD, btnR, btnL}),
    .deb  (deb)
  );

  always_comb begin
    dir = 4'b0000;
    if      (deb[3]) dir = 4'b1000;
    else if (deb[2]) dir = 4'b0100;
    else if (deb[1]) dir = 4'b0010;
    else if (deb[0]) dir = 4'b0001;
  end

  // last_q remembers the direction of the current run so a new winner restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    stb_d   = 1'b0;
    btns_d  = 4'b0000;
    if (holdOff || dir == 4'b0000) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || dir != last_q) begin
      state_d = FIRST;
      stb_d   = 1'b1;
      btns_d  = dir;
      last_d  = dir;
    end else begin
      case (state_q)
        FIRST: begin
          state_d = DELAY;
          cnt_d   = CNT_W'(REPEAT_DELAY - 1);
        end
        RPT: begin
          state_d = DELAY;
          cnt_d   = CNT_W'(REPEAT_PERIOD - 1);
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = RPT;
            stb_d   = 1'b1;
            btns_d  = dir;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 4'b0000;
      btns_q  <= 4'b0000;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      btns_q  <= btns_d;
      stb_q   <= stb_d;
    end
  end

  assign moveStb = stb_q;
  assign btns    = btns_q;
  assign held    = |deb;
endmodule

// File: tb/tb_move_request_gen.sv
// Scoreboard bench for move_request_gen: expected strobe cycle/direction pushed
// at stimulus time, popped and compared whenever moveStb is seen.

module tb_move_request_gen;
  logic       clk, rst_n, btnU, btnD, btnR, btnL, holdOff;
  logic [3:0] btns;
  logic       moveStb, held;

  typedef struct { int cyc; logic [3:0] dir; } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  move_request_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btnU   (btnU),
    .btnD   (btnD),
    .btnR   (btnR),
    .btnL   (btnL),
    .holdOff(holdOff),
    .btns   (btns),
    .moveStb(moveStb),
    .held   (held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] d);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Outputs change on posedge; sampled on the following negedge.
  always @(negedge clk) begin
    exp_t e;
    if (moveStb) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_stb", {28'd0, btns}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("stb_cycle", cyc, e.cyc);
        chk("stb_dir", {28'd0, btns}, {28'd0, e.dir});
      end
    end else begin
      chk("btns_idle_zero", {28'd0, btns}, 32'd0);
    end
  end

  task automatic drain(input string tag);
    chk(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int c;
    rst_n = 1'b0; btnU = 0; btnD = 0; btnR = 0; btnL = 0; holdOff = 0;
    #1;
    chk("rst_stb", moveStb, 0);
    chk("rst_btns", btns, 0);
    chk("rst_held", held, 0);
    step(3);
    rst_n = 1'b1;
    step(3);

    // 1: U held 6 cycles -> single strobe, no repeat
    c = cyc; btnU = 1; push(c + 7, 4'b1000);
    step(6); btnU = 0;
    step(25);
    drain("t1_missing");
    chk("t1_held", held, 0);

    // 2: R held 40 cycles -> first strobe, gap 11, then gaps of 5
    c = cyc; btnR = 1;
    push(c + 7, 4'b0010);
    for (int t = c + 18; t <= c + 46; t += 5) push(t, 4'b0010);
    step(20);
    chk("t2_held", held, 1);
    step(20); btnR = 0;
    step(20);
    drain("t2_missing");

    // 3: 3-cycle glitch on L never debounces
    btnL = 1;
    step(3); btnL = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t3_held", held, 0);
    end
    drain("t3_missing");

    // 4: L held, U added -> U preempts and restarts repeat timing
    c = cyc; btnL = 1;
    push(c + 7, 4'b0001);
    step(9); btnU = 1;
    push(c + 16, 4'b1000);
    push(c + 27, 4'b1000);
    push(c + 32, 4'b1000);
    step(21); btnU = 0; btnL = 0;
    step(20);
    drain("t4_missing");

    // 5: holdOff suppresses; dropping it strobes on the next cycle
    c = cyc; holdOff = 1; btnD = 1;
    step(20);
    chk("t5_held", held, 1);
    holdOff = 0;
    push(c + 21, 4'b0100);
    step(2); btnD = 0;
    step(20);
    drain("t5_missing");

    // 6: reset mid-DELAY clears outputs; still-held button re-debounces
    c = cyc; btnD = 1;
    push(c + 7, 4'b0100);
    step(12);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stb", moveStb, 0);
    chk("t6_rst_btns", btns, 0);
    chk("t6_rst_held", held, 0);
    step(2);
    rst_n = 1'b1;
    push(c + 21, 4'b0100);
    step(11); btnD = 0;
    step(20);
    drain("t6_missing");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
